// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: burst/response encodings, size helper and
// the write-channel FSM state type used by the AXI masters.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_AW,
        WR_W,
        WR_B
    } wr_state_t;

    // AxSIZE encoding for a beat of the given number of bytes.
    function automatic logic [2:0] axi_size(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi_master_wr.sv
// AXI4 write master: turns one wr_start request into one INCR burst on
// AW/W/B and pops the first-word-fall-through write FIFO on every W beat.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   wr_start/addr/len request from the controller (sampled in IDLE)
//   wr_data          write-FIFO dout, passed straight to m_axi_wdata
//   wr_ready         high only in IDLE
//   writing          W handshake, used as FIFO rd_en
//   wr_done          one-cycle pulse after the B handshake
//   wr_err           sticky BRESP error flag
//   m_axi_aw*/w*/b*  AXI4 write address, data and response channels
//
// Build option: define AXI_WR_BRESP_CHK_EN to latch a non-OKAY BRESP into
// wr_err; otherwise wr_err is tied low and bresp is ignored.
module axi_master_wr
    import axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 30,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_start,
    input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [7:0]                  wr_len,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
    output logic                        wr_ready,
    output logic                        writing,
    output logic                        wr_done,
    output logic                        wr_err,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready
);

    localparam logic [2:0] BEAT_SIZE = axi_size(AXI_DATA_WIDTH / 8);

    wr_state_t                 state;
    logic                      ready_q;
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic                      wlast_q;
    logic                      bready_q;
    logic                      done_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [7:0]                cnt_q;
    logic [7:0]                cnt_nxt;

    assign cnt_nxt = 8'(cnt_q + 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WR_IDLE;
            ready_q   <= 1'b1;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                WR_IDLE: begin
                    if (wr_start) begin
                        addr_q    <= wr_addr;
                        len_q     <= wr_len;
                        awvalid_q <= 1'b1;
                        ready_q   <= 1'b0;
                        state     <= WR_AW;
                    end
                end
                WR_AW: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (len_q == 8'd0);
                        cnt_q     <= '0;
                        state     <= WR_W;
                    end
                end
                WR_W: begin
                    if (m_axi_wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state    <= WR_B;
                        end else begin
                            // wlast is registered one beat ahead
                            cnt_q   <= cnt_nxt;
                            wlast_q <= (cnt_nxt == len_q);
                        end
                    end
                end
                WR_B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                        state    <= WR_IDLE;
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

`ifdef AXI_WR_BRESP_CHK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bready_q && m_axi_bvalid
                     && (m_axi_bresp != RESP_OKAY)) begin
            err_q <= 1'b1;
        end
    end

    assign wr_err = err_q;
`else
    logic unused_bresp;

    assign unused_bresp = ^m_axi_bresp;
    assign wr_err       = 1'b0;
`endif

    assign wr_ready      = ready_q;
    assign writing       = wvalid_q & m_axi_wready;
    assign wr_done       = done_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = BEAT_SIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_master_wr.sv
// Self-checking bench for axi_master_wr: FIFO model plus expected-beat
// scoreboard, AW stalls, random wready, held start, BRESP and reset.
module tb_axi_master_wr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_start = 1'b0;
    logic [29:0] wr_addr = '0;
    logic [7:0]  wr_len = '0;
    logic [63:0] wr_data = '0;
    logic        wr_ready;
    logic        writing;
    logic        wr_done;
    logic        wr_err;
    logic [29:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    int checks = 0;
    int failures = 0;
    logic exp_err = 1'b0;

    logic [63:0] fifo[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    axi_master_wr dut (
        .clk           (clk),
        .rst           (rst),
        .wr_start      (wr_start),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .writing       (writing),
        .wr_done       (wr_done),
        .wr_err        (wr_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    // Runs one burst; called and returns at a negedge.
    task automatic do_burst(
        input  logic [29:0] addr,
        input  logic [7:0]  len,
        input  int          aw_stall,
        input  bit          rnd_w,
        input  logic [1:0]  bresp,
        input  bit          hold,
        output int          beats,
        output int          wv_cyc,
        output int          aw_hs,
        output int          dones
    );
        int   aw_cnt;
        bit   got_done;
        bit   w_hs;
        logic [63:0] d;
        logic [63:0] e;
        beats = 0; wv_cyc = 0; aw_hs = 0; dones = 0;
        aw_cnt = 0; got_done = 0;
        for (int i = 0; i <= int'(len); i++) begin
            d = {$urandom, $urandom};
            fifo.push_back(d);
            exp_q.push_back(d);
        end
        wr_data  = fifo[0];
        wr_addr  = addr;
        wr_len   = len;
        wr_start = 1'b1;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            m_axi_awready = (aw_cnt >= aw_stall);
            m_axi_wready  = rnd_w ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_bvalid  = m_axi_bready;
            m_axi_bresp   = bresp;
            #1;
            if (m_axi_awvalid) begin
                checks++;
                if (m_axi_awaddr !== addr || m_axi_awlen !== len ||
                    m_axi_awsize !== 3'd3 || m_axi_awburst !== 2'b01) begin
                    failures++;
                    $display("FAIL aw_fields: got %h/%0d/%0d/%0d want %h/%0d/3/1",
                             m_axi_awaddr, m_axi_awlen, m_axi_awsize,
                             m_axi_awburst, addr, len);
                end
                checks++;
                if (m_axi_wvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL w_before_aw: wvalid=%b want 0", m_axi_wvalid);
                end
                if (m_axi_awready) aw_hs++;
                else aw_cnt++;
            end
            if (m_axi_wvalid) wv_cyc++;
            checks++;
            if (writing !== (m_axi_wvalid & m_axi_wready)) begin
                failures++;
                $display("FAIL writing_def: got %b want %b", writing,
                         m_axi_wvalid & m_axi_wready);
            end
            if (writing) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL w_extra: got beat %0d want none", beats);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (m_axi_wdata !== e) begin
                        failures++;
                        $display("FAIL wdata: got %h want %h", m_axi_wdata, e);
                    end
                end
                checks++;
                if (m_axi_wlast !== (beats == int'(len))) begin
                    failures++;
                    $display("FAIL wlast: beat %0d got %b want %b", beats,
                             m_axi_wlast, beats == int'(len));
                end
                beats++;
            end
`ifdef AXI_WR_BRESP_CHK_EN
            if (m_axi_bvalid && m_axi_bready && bresp != 2'b00) exp_err = 1'b1;
`endif
            if (wr_done) begin
                dones++;
                got_done = 1;
                checks++;
                if (wr_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_at_done: got %b want 1", wr_ready);
                end
                checks++;
                if (wr_err !== exp_err) begin
                    failures++;
                    $display("FAIL wr_err: got %b want %b", wr_err, exp_err);
                end
                wr_start = 1'b0;
            end
            if (!wr_ready && !hold) wr_start = 1'b0;
            w_hs = writing;
            @(posedge clk);
            #1;
            if (w_hs && fifo.size() != 0) void'(fifo.pop_front());
            wr_data = (fifo.size() != 0) ? fifo[0] : '0;
            @(negedge clk);
        end
        m_axi_bvalid = 1'b0;
        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL timeout: got no wr_done want wr_done");
        end
        #1;
        checks++;
        if (wr_done !== 1'b0 || m_axi_awvalid !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: got done=%b awvalid=%b want 0/0",
                     wr_done, m_axi_awvalid);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL beats_left: got %0d want 0", exp_q.size());
        end
        exp_q.delete();
        fifo.delete();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (wr_ready !== 1'b1 || m_axi_awvalid !== 1'b0 ||
            m_axi_wvalid !== 1'b0 || m_axi_wlast !== 1'b0 ||
            m_axi_bready !== 1'b0 || wr_done !== 1'b0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: got rdy=%b aw=%b w=%b l=%b b=%b d=%b e=%b want 1000000",
                     wr_ready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast,
                     m_axi_bready, wr_done, wr_err);
        end
        checks++;
        if (m_axi_awaddr !== '0 || m_axi_awlen !== '0 ||
            m_axi_wstrb !== 8'hff) begin
            failures++;
            $display("FAIL reset_regs: got %h/%0d/%h want 0/0/ff",
                     m_axi_awaddr, m_axi_awlen, m_axi_wstrb);
        end
    endtask

    task automatic test_basic();
        int b, wv, a, d;
        do_burst(30'h100, 8'd7, 0, 0, 2'b00, 0, b, wv, a, d);
        checks++;
        if (b != 8 || wv != 8 || a != 1 || d != 1) begin
            failures++;
            $display("FAIL basic_counts: got b=%0d wv=%0d aw=%0d d=%0d want 8 8 1 1",
                     b, wv, a, d);
        end
    endtask

    task automatic test_single();
        int b, wv, a, d;
        do_burst(30'h208, 8'd0, 0, 0, 2'b00, 0, b, wv, a, d);
        checks++;
        if (b != 1 || a != 1 || d != 1) begin
            failures++;
            $display("FAIL single_counts: got b=%0d aw=%0d d=%0d want 1 1 1",
                     b, a, d);
        end
    endtask

    task automatic test_aw_stall();
        int b, wv, a, d;
        do_burst(30'h1000, 8'd3, 5, 0, 2'b00, 0, b, wv, a, d);
        checks++;
        if (b != 4 || a != 1 || d != 1) begin
            failures++;
            $display("FAIL stall_counts: got b=%0d aw=%0d d=%0d want 4 1 1",
                     b, a, d);
        end
    endtask

    task automatic test_wready_rand();
        int b, wv, a, d;
        do_burst(30'h3f00, 8'd15, 1, 1, 2'b00, 0, b, wv, a, d);
        checks++;
        if (b != 16 || a != 1 || d != 1) begin
            failures++;
            $display("FAIL rand_counts: got b=%0d aw=%0d d=%0d want 16 1 1",
                     b, a, d);
        end
    endtask

    task automatic test_back_to_back();
        int b, wv, a, d;
        do_burst(30'h400, 8'd2, 0, 0, 2'b00, 1, b, wv, a, d);
        checks++;
        if (b != 3 || a != 1 || d != 1) begin
            failures++;
            $display("FAIL hold_counts: got b=%0d aw=%0d d=%0d want 3 1 1",
                     b, a, d);
        end
        do_burst(30'h500, 8'd1, 2, 0, 2'b00, 1, b, wv, a, d);
        checks++;
        if (b != 2 || a != 1 || d != 1) begin
            failures++;
            $display("FAIL hold2_counts: got b=%0d aw=%0d d=%0d want 2 1 1",
                     b, a, d);
        end
    endtask

    task automatic test_bresp();
        int b, wv, a, d;
        do_burst(30'h600, 8'd1, 0, 0, 2'b10, 0, b, wv, a, d);
        do_burst(30'h700, 8'd1, 0, 0, 2'b00, 0, b, wv, a, d);
        checks++;
        if (wr_err !== exp_err) begin
            failures++;
            $display("FAIL err_sticky: got %b want %b", wr_err, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int b, wv, a, d;
        wr_addr = 30'h800; wr_len = 8'd7; wr_start = 1'b1;
        wr_data = 64'h1234;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (!wr_ready) wr_start = 1'b0;
            if (m_axi_wvalid) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_w_timeout: got no wvalid want wvalid");
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        exp_err = 1'b0;
        checks++;
        if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 ||
            m_axi_wlast !== 1'b0 || m_axi_bready !== 1'b0 ||
            wr_ready !== 1'b1 || wr_err !== 1'b0 || writing !== 1'b0) begin
            failures++;
            $display("FAIL async_rst: got aw=%b w=%b l=%b b=%b rdy=%b e=%b wr=%b want 0000100",
                     m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                     wr_ready, wr_err, writing);
        end
        @(negedge clk);
        rst = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        @(negedge clk);
        do_burst(30'h900, 8'd3, 1, 0, 2'b00, 0, b, wv, a, d);
        checks++;
        if (b != 4 || a != 1 || d != 1) begin
            failures++;
            $display("FAIL post_rst_counts: got b=%0d aw=%0d d=%0d want 4 1 1",
                     b, a, d);
        end
    endtask

    initial begin
        rst = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_single();
        test_aw_stall();
        test_wready_rand();
        test_back_to_back();
        test_bresp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
